// File: rtl/fifo_test_pkg.sv
// Shared settings for the FIFO loop-back test (write and read sides).
// Holds the FIFO geometry and the read-side controller state encoding.
package fifo_test_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ERR_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } rd_state_t;

endpackage

// File: rtl/rd_fifo_check_seq_checker.sv
// Compares each word read from the FIFO against an incrementing sequence.
// Counts words and mismatches with saturation; republishes the word as data_out/data_vld.
module seq_checker #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              rd_d1,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [ERR_W-1:0]  err_cnt
);

    logic [DATA_W-1:0] exp_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            data_vld <= 1'b0;
            word_cnt <= '0;
            err_cnt  <= '0;
            exp_word <= '0;
        end else begin
            data_vld <= rd_d1;
            if (rd_d1) begin
                data_out <= q;
            end
            if (clear) begin
                word_cnt <= '0;
                err_cnt  <= '0;
                exp_word <= '0;
            end else if (rd_d1) begin
                if (word_cnt != '1) begin
                    word_cnt <= word_cnt + 1'b1;
                end
                // Compare against the pre-increment expectation; the sequence wraps freely.
                if ((q != exp_word) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                exp_word <= exp_word + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_fifo_check.sv
// Read side of the FIFO loop-back test: drains a full FIFO on a key press,
// checks the incrementing sequence and reports a per-burst pass/fail verdict.
module rd_fifo_check #(
    parameter int unsigned DATA_W = fifo_test_pkg::DATA_W,
    parameter int unsigned DEPTH  = fifo_test_pkg::DEPTH,
    parameter int unsigned ERR_W  = fifo_test_pkg::ERR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdfull,
    input  logic              rdempty,
    input  logic [DATA_W-1:0] q,
    input  logic              key_rd,
    output logic              rdreq,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              done,
    output logic              pass,
    output logic              led_rd
);

    import fifo_test_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic             start;
    logic             rd_d1;
    logic [CNT_W-1:0] word_cnt;

    assign rdreq  = (state == READ) && !rdempty;
    assign led_rd = !rdempty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (!key_rd && rdfull) begin
                    state_nxt = READ;
                    start     = 1'b1;
                end
            end
            READ: begin
                if (rdempty) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The last accepted read still has its data in flight until rd_d1 clears.
                if (!rd_d1) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d1 <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            rd_d1 <= rdreq;
            done  <= (state == REPORT);
            if (start) begin
                pass <= 1'b0;
            end else if (state == REPORT) begin
                pass <= (err_cnt == '0) && (word_cnt == CNT_W'(DEPTH));
            end
        end
    end

    seq_checker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ERR_W  (ERR_W)
    ) u_seq_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .rd_d1    (rd_d1),
        .q        (q),
        .data_out (data_out),
        .data_vld (data_vld),
        .word_cnt (word_cnt),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_rd_fifo_check.sv
// Bench for rd_fifo_check: queue-based FIFO model, table of bursts, random bursts
// and hand-written corner sequences (half-full key press, reset mid-burst).
module tb_rd_fifo_check;

    localparam int DW  = 8;
    localparam int DEP = 256;
    localparam int EW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rdfull;
    logic          rdempty;
    logic [DW-1:0] q = '0;
    logic          key_rd = 1'b1;
    logic          rdreq;
    logic [DW-1:0] data_out;
    logic          data_vld;
    logic [EW-1:0] err_cnt;
    logic          done;
    logic          pass;
    logic          led_rd;

    int errors = 0;
    int checks = 0;

    rd_fifo_check #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .ERR_W  (EW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdfull   (rdfull),
        .rdempty  (rdempty),
        .q        (q),
        .key_rd   (key_rd),
        .rdreq    (rdreq),
        .data_out (data_out),
        .data_vld (data_vld),
        .err_cnt  (err_cnt),
        .done     (done),
        .pass     (pass),
        .led_rd   (led_rd)
    );

    always #5 clk = ~clk;

    // FIFO model: words popped on an accepted rdreq appear on q one cycle later.
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] popped[$];
    logic [DW-1:0] img[$];
    int            fifo_cnt = 0;
    logic          force_empty = 1'b0;
    int            pop_cnt = 0;
    int            stop_after = 0;

    assign rdempty = (fifo_cnt == 0) || force_empty;
    assign rdfull  = (fifo_cnt == DEP);

    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (rdreq && (fifo.size() > 0)) begin
            w = fifo.pop_front();
            q <= w;
            popped.push_back(w);
            pop_cnt = pop_cnt + 1;
        end
        fifo_cnt    <= fifo.size();
        force_empty <= (stop_after > 0) && (pop_cnt >= stop_after);
    end

    // Continuous protocol monitor.
    int   vld_cnt = 0;
    int   done_cnt = 0;
    int   rdreq_seen = 0;
    logic rq_h1 = 1'b0;
    logic rq_h2 = 1'b0;

    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (!rst_n) begin
            rq_h1 = 1'b0;
            rq_h2 = 1'b0;
        end else begin
            checks++;
            if (rdreq && rdempty) begin
                errors++;
                $display("FAIL rdreq_on_empty: rdreq=%0b rdempty=%0b, required never both high", rdreq, rdempty);
            end
            checks++;
            if (data_vld !== rq_h2) begin
                errors++;
                $display("FAIL vld_latency: data_vld=%0b, required %0b (rdreq two cycles earlier)", data_vld, rq_h2);
            end
            if (data_vld) begin
                vld_cnt++;
                checks++;
                if (popped.size() == 0) begin
                    errors++;
                    $display("FAIL data_out: data_vld with no word read, data_out=%0d", data_out);
                end else begin
                    w = popped.pop_front();
                    if (data_out !== w) begin
                        errors++;
                        $display("FAIL data_out: got %0d, required %0d", data_out, w);
                    end
                end
            end
            if (done) done_cnt++;
            if (rdreq) rdreq_seen++;
            rq_h2 = rq_h1;
            rq_h1 = rdreq;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic build_img(input int n, input int bad_idx, input int bad_val, input bit all_bad);
        logic [DW-1:0] w;
        img.delete();
        for (int i = 0; i < n; i++) begin
            w = DW'(i);
            if (all_bad) w = w ^ 8'hFF;
            if (i == bad_idx) w = DW'(bad_val);
            img.push_back(w);
        end
    endtask

    // Called at a negedge; FIFO flags reflect the new contents after the next posedge.
    task automatic load(input int stop_at);
        fifo.delete();
        popped.delete();
        foreach (img[i]) fifo.push_back(img[i]);
        pop_cnt    = 0;
        stop_after = stop_at;
        vld_cnt    = 0;
        done_cnt   = 0;
        rdreq_seen = 0;
        @(negedge clk);
    endtask

    task automatic pulse_key();
        key_rd = 1'b0;
        @(negedge clk);
        key_rd = 1'b1;
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 2000 && pop_cnt < n; i++) @(negedge clk);
        chk("pop_wait", int'(pop_cnt >= n), 1);
    endtask

    task automatic run_burst(input string name, input int stop_at, input int refill_n,
                             input int exp_words, input int exp_err, input bit exp_pass);
        load(stop_at);
        pulse_key();
        if (refill_n > 0) begin
            wait_pops(50);
            for (int k = 0; k < refill_n; k++) fifo.push_back(DW'(k));
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({name, "_words"}, vld_cnt, exp_words);
        chk({name, "_err_cnt"}, int'(err_cnt), exp_err);
        chk({name, "_pass"}, int'(pass), int'(exp_pass));
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_unseen"}, popped.size(), 0);
    endtask

    function automatic int model_err(input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (img[i] != DW'(i)) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    typedef struct {
        string name;
        int    stop_at;
        int    refill_n;
        int    bad_idx;
        int    bad_val;
        bit    all_bad;
        int    exp_words;
        int    exp_err;
        bit    exp_pass;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"clean",      0,   0,  -1, 0,      1'b0, 256, 0,   1'b1};
        vecs[1] = '{"bad17",      0,   0,  17, 'h99,   1'b0, 256, 1,   1'b0};
        vecs[2] = '{"stop100",    100, 0,  -1, 0,      1'b0, 100, 0,   1'b0};
        vecs[3] = '{"refill10",   0,   10, -1, 0,      1'b0, 266, 0,   1'b0};
        vecs[4] = '{"all_bad",    0,   0,  -1, 0,      1'b1, 256, 255, 1'b0};
        vecs[5] = '{"bad_last",   0,   0,  255, 0,     1'b0, 256, 1,   1'b0};
        vecs[6] = '{"stop1",      1,   0,  -1, 0,      1'b0, 1,   0,   1'b0};

        repeat (3) @(negedge clk);
        chk("reset_rdreq", int'(rdreq), 0);
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_data_vld", int'(data_vld), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_led_rd", int'(led_rd), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            build_img(DEP, vecs[i].bad_idx, vecs[i].bad_val, vecs[i].all_bad);
            run_burst(vecs[i].name, vecs[i].stop_at, vecs[i].refill_n,
                      vecs[i].exp_words, vecs[i].exp_err, vecs[i].exp_pass);
        end

        // Key press while only half full: must be ignored.
        build_img(DEP / 2, -1, 0, 1'b0);
        load(0);
        chk("half_led_rd", int'(led_rd), 1);
        pulse_key();
        repeat (20) @(negedge clk);
        chk("half_rdreq_seen", rdreq_seen, 0);
        chk("half_done_cnt", done_cnt, 0);
        chk("half_vld_cnt", vld_cnt, 0);

        // Reset asserted mid-burst, then a clean burst.
        build_img(DEP, -1, 0, 1'b0);
        load(0);
        pulse_key();
        wait_pops(50);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rdreq", int'(rdreq), 0);
        chk("rst_mid_data_out", int'(data_out), 0);
        chk("rst_mid_data_vld", int'(data_vld), 0);
        chk("rst_mid_err_cnt", int'(err_cnt), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_pass", int'(pass), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_no_done", done_cnt, 0);
        @(negedge clk);
        build_img(DEP, -1, 0, 1'b0);
        run_burst("after_reset", 0, 0, 256, 0, 1'b1);

        // Random corruptions and early stops against the reference model.
        for (int r = 0; r < 6; r++) begin
            int stop_at;
            int n_bad;
            int words;
            int e;
            stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 255)) : 0;
            build_img(DEP, -1, 0, 1'b0);
            n_bad = $urandom_range(0, 4);
            for (int b = 0; b < n_bad; b++) img[$urandom_range(0, DEP - 1)] = DW'($urandom_range(0, 255));
            words = (stop_at > 0) ? stop_at : DEP;
            e = model_err(words);
            run_burst("random", stop_at, 0, words, e, (e == 0) && (words == DEP));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
